// File: rtl/corner_framer.sv
// Corner framer: wraps each frame's detector corners in a header and a trailer
// and queues all words through one show-ahead FIFO with a single write port.
module corner_framer #(
    parameter int DEPTH       = 512,
    parameter int TAIL_CYCLES = 64,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic        c,
    input  logic        rst,
    input  logic        fv,
    input  logic [31:0] d,
    input  logic        dv,
    output logic [31:0] q,
    output logic        qv,
    input  logic        qready,
    output logic [AW:0] fill,
    output logic [15:0] drop_cnt,
    output logic [1:0]  state_dbg
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        TAIL  = 2'd2,
        SKIP  = 2'd3
    } state_t;

    // Handshake: qv is high whenever the FIFO holds a word and q is that head
    // word; the word is consumed on each rising edge of c where qv & qready.

    state_t        state, state_nx;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nx;
    logic          fv_q, armed, pending, pending_nx;
    logic [15:0]   frame_num, frame_num_nx;
    logic [15:0]   corner_cnt, corner_cnt_nx;
    logic [15:0]   tail_cnt, tail_cnt_nx;
    logic [15:0]   drop_cnt_nx;
    logic          ovf, ovf_nx;
    logic          rise, has_room, accepting, drop_inc;
    logic          push, pop;
    logic [31:0]   push_data;

    // armed stays low until fv has been seen low, so a frame already running
    // when reset is released never produces a header.
    assign rise      = fv & ~fv_q & armed;
    assign has_room  = (count <= (AW+1)'(DEPTH - 2));
    assign qv        = (count != '0);
    assign q         = mem[rd_ptr];
    assign pop       = qv & qready;
    assign fill      = count;
    assign state_dbg = state;

    always_comb begin
        state_nx      = state;
        pending_nx    = pending;
        frame_num_nx  = frame_num;
        corner_cnt_nx = corner_cnt;
        tail_cnt_nx   = tail_cnt;
        ovf_nx        = ovf;
        accepting     = 1'b0;
        drop_inc      = 1'b0;
        push          = 1'b0;
        push_data     = d;

        case (state)
            IDLE: begin
                if (rise || pending) begin
                    pending_nx   = 1'b0;
                    frame_num_nx = frame_num + 16'd1;
                    drop_inc     = dv;
                    if (has_room) begin
                        push          = 1'b1;
                        push_data     = {8'hA5, 8'h00, frame_num};
                        corner_cnt_nx = 16'd0;
                        ovf_nx        = 1'b0;
                        state_nx      = FRAME;
                    end else begin
                        state_nx = SKIP;
                    end
                end
            end
            FRAME: begin
                accepting = 1'b1;
                if (!fv) begin
                    tail_cnt_nx = 16'(TAIL_CYCLES);
                    state_nx    = TAIL;
                end
            end
            TAIL: begin
                // A new frame starting inside the tail closes this one now and
                // leaves its header owed for the next cycle.
                if (rise || tail_cnt == 16'd0) begin
                    push       = 1'b1;
                    push_data  = {8'h5A, ovf | dv, 7'b0, corner_cnt};
                    drop_inc   = dv;
                    pending_nx = rise;
                    state_nx   = IDLE;
                end else begin
                    accepting   = 1'b1;
                    tail_cnt_nx = tail_cnt - 16'd1;
                end
            end
            SKIP: begin
                drop_inc = dv;
                if (!fv) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // The last free slot is always kept for the trailer.
        if (accepting && dv) begin
            if (has_room) begin
                push = 1'b1;
                if (corner_cnt != 16'hFFFF) corner_cnt_nx = corner_cnt + 16'd1;
            end else begin
                ovf_nx   = 1'b1;
                drop_inc = 1'b1;
            end
        end
    end

    always_comb begin
        drop_cnt_nx = drop_cnt;
        if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt_nx = drop_cnt + 16'd1;
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_nx = count + (AW+1)'(1);
            2'b01:   count_nx = count - (AW+1)'(1);
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fv_q       <= 1'b0;
            armed      <= 1'b0;
            pending    <= 1'b0;
            frame_num  <= 16'd0;
            corner_cnt <= 16'd0;
            tail_cnt   <= 16'd0;
            drop_cnt   <= 16'd0;
            ovf        <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state      <= state_nx;
            fv_q       <= fv;
            armed      <= armed | ~fv;
            pending    <= pending_nx;
            frame_num  <= frame_num_nx;
            corner_cnt <= corner_cnt_nx;
            tail_cnt   <= tail_cnt_nx;
            drop_cnt   <= drop_cnt_nx;
            ovf        <= ovf_nx;
            count      <= count_nx;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge c) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_corner_framer.sv
// Bench for corner_framer: directed frame scenarios plus random frames, all
// checked every cycle against a frame-level reference model.
module tb_corner_framer;
  localparam int DEPTH = 8;
  localparam int TAIL  = 16;
  localparam int FW    = 4;

  // clock / reset
  logic          c = 1'b0;
  logic          rst;
  logic          fv, dv, qready;
  logic [31:0]   d;
  logic [31:0]   q;
  logic          qv;
  logic [FW-1:0] fill;
  logic [15:0]   drop_cnt;
  logic [1:0]    state_dbg;

  always #5 c = ~c;

  corner_framer #(.DEPTH(DEPTH), .TAIL_CYCLES(TAIL)) dut (
    .c(c), .rst(rst), .fv(fv), .d(d), .dv(dv), .q(q), .qv(qv),
    .qready(qready), .fill(fill), .drop_cnt(drop_cnt), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: words owed to the consumer, in order
  logic [31:0] exp_q[$];
  int  m_mode;      // 0 waiting for a frame, 1 collecting, 2 discarding a frame
  int  m_fall_age;  // cycles since fv fell in the collected frame, -1 while fv high
  bit  m_hdr_owed;
  bit  m_fv_prev;
  bit  m_armed;
  int  m_frame;
  int  m_cnt;
  bit  m_ovf;
  int  m_drops;

  task automatic model_reset();
    exp_q.delete();
    m_mode = 0; m_fall_age = -1; m_hdr_owed = 0; m_fv_prev = 0; m_armed = 0;
    m_frame = 0; m_cnt = 0; m_ovf = 0; m_drops = 0;
  endtask

  task automatic model_drop();
    if (m_drops < 65535) m_drops++;
  endtask

  task automatic model_step();
    bit          room, popping, start, wr_en;
    logic [31:0] wr;
    room    = exp_q.size() <= DEPTH - 2;
    popping = exp_q.size() > 0 && qready;
    start   = fv && !m_fv_prev && m_armed;
    wr_en   = 0;
    wr      = '0;
    case (m_mode)
      0: if (start || m_hdr_owed) begin
        m_hdr_owed = 0;
        if (dv) model_drop();
        if (room) begin
          wr_en = 1; wr = {8'hA5, 8'h00, 16'(m_frame)};
          m_cnt = 0; m_ovf = 0; m_fall_age = -1; m_mode = 1;
        end else begin
          m_mode = 2;
        end
        m_frame = (m_frame + 1) % 65536;
      end
      1: begin
        if (m_fall_age < 0 && !fv) m_fall_age = 0;
        else if (m_fall_age >= 0) m_fall_age++;
        if (m_fall_age > 0 && (start || m_fall_age == TAIL + 1)) begin
          if (dv) begin m_ovf = 1; model_drop(); end
          wr_en = 1; wr = {8'h5A, m_ovf, 7'b0, 16'(m_cnt)};
          m_hdr_owed = start; m_mode = 0;
        end else if (dv) begin
          if (room) begin
            wr_en = 1; wr = d;
            if (m_cnt < 65535) m_cnt++;
          end else begin
            m_ovf = 1; model_drop();
          end
        end
      end
      default: begin
        if (dv) model_drop();
        if (!fv) m_mode = 0;
      end
    endcase
    if (popping) void'(exp_q.pop_front());
    if (wr_en) exp_q.push_back(wr);
    m_fv_prev = fv;
    m_armed   = m_armed | !fv;
  endtask

  task automatic compare();
    check("qv", 32'(qv), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("q", q, exp_q[0]);
    check("fill", 32'(fill), 32'(exp_q.size()));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
  endtask

  // driver
  logic [31:0] pop_log[$];
  logic [31:0] want[$];

  task automatic cycle(input bit f, input bit v, input logic [31:0] dd, input bit r);
    fv = f; dv = v; d = dd; qready = r;
    if (qv && qready) pop_log.push_back(q);
    @(posedge c);
    if (!rst) model_step();
    @(negedge c);
    compare();
  endtask

  task automatic idle(input int n, input bit f, input bit r);
    for (int k = 0; k < n; k++) cycle(f, 1'b0, 32'd0, r);
  endtask

  task automatic corner(input bit r);
    logic [31:0] w;
    w = $urandom;
    want.push_back(w);
    cycle(1'b1, 1'b1, w, r);
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_len"}, 32'(pop_log.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < pop_log.size(); i++) check(tag, pop_log[i], want[i]);
  endtask

  function automatic bit rdy(input bit slow);
    return slow ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
  endfunction

  logic [31:0] w;
  logic [31:0] stored[$];

  initial begin
    rst = 1'b1; fv = 1'b0; dv = 1'b0; d = '0; qready = 1'b0;
    model_reset();
    repeat (3) @(negedge c);
    check("rst_qv", 32'(qv), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    rst = 1'b0;

    // partial frame, then reset in the middle of it with fv high and dv toggling
    idle(2, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, $urandom, 1'b0);
    check("pre_rst_fill", 32'(fill), 32'd4);
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'(k), $urandom, 1'b1);
    check("mid_rst_qv", 32'(qv), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'(k), $urandom, 1'b1);
    check("no_hdr_fill", 32'(fill), 32'd0);
    check("no_hdr_qv", 32'(qv), 32'd0);

    // first frame: three corners
    idle(3, 1'b0, 1'b1);
    pop_log.delete(); want.delete();
    want.push_back(32'hA500_0000);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    check("hdr_latency", q, 32'hA500_0000);
    for (int k = 0; k < 3; k++) corner(1'b1);
    idle(1, 1'b1, 1'b1);
    idle(22, 1'b0, 1'b1);
    want.push_back(32'h5A00_0003);
    compare_log("frame0");

    // late corners: offset 5 inside the tail window, offset 20 after the trailer
    pop_log.delete(); want.delete();
    want.push_back(32'hA500_0001);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    idle(3, 1'b1, 1'b1);
    for (int k = 0; k <= 25; k++) begin
      w = $urandom;
      if (k == 5) want.push_back(w);
      cycle(1'b0, (k == 5 || k == 20), w, 1'b1);
    end
    want.push_back(32'h5A00_0001);
    compare_log("tail");
    check("late_drop_cnt", 32'(drop_cnt), 32'd0);

    // ten corners into a stalled FIFO
    want.delete(); stored.delete();
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      w = $urandom;
      if (k < 6) stored.push_back(w);
      cycle(1'b1, 1'b1, w, 1'b0);
    end
    idle(20, 1'b0, 1'b0);
    check("ovf_fill", 32'(fill), 32'd8);
    check("ovf_drops", 32'(drop_cnt), 32'd4);

    // next frame arrives with the FIFO full and is skipped
    idle(2, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, $urandom, 1'b0);
    idle(3, 1'b0, 1'b0);
    check("skip_fill", 32'(fill), 32'd8);
    check("skip_drops", 32'(drop_cnt), 32'd8);
    pop_log.delete(); want.delete();
    want.push_back(32'hA500_0002);
    foreach (stored[i]) want.push_back(stored[i]);
    want.push_back(32'h5A80_0006);
    idle(12, 1'b0, 1'b1);
    compare_log("ovf");

    // frame after the skip, and fv re-rising on the third tail cycle
    pop_log.delete(); want.delete();
    want.push_back(32'hA500_0004);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    check("skip_hdr", q, 32'hA500_0004);
    for (int k = 0; k < 2; k++) corner(1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      w = $urandom;
      want.push_back(w);
      cycle(1'b0, 1'b1, w, 1'b1);
    end
    want.push_back(32'h5A00_0004);
    want.push_back(32'hA500_0005);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    corner(1'b1);
    idle(22, 1'b0, 1'b1);
    want.push_back(32'h5A00_0001);
    compare_log("rerise");

    // random frames with random back-pressure
    for (int f = 0; f < 60; f++) begin
      int gap, len;
      bit slow;
      gap  = $urandom_range(1, 25);
      len  = $urandom_range(2, 30);
      slow = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < gap; k++) cycle(1'b0, 1'($urandom_range(0, 1)), $urandom, rdy(slow));
      for (int k = 0; k < len; k++) cycle(1'b1, 1'($urandom_range(0, 1)), $urandom, rdy(slow));
    end
    idle(40, 1'b0, 1'b1);
    check("final_empty", 32'(fill), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
